// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment vector type, blank pattern and the
// active-low hex glyph table for a common-anode display.
package seg7_pkg;

    // Segment order is {g,f,e,d,c,b,a}, active-low.
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;

    localparam seg_t GLYPHS [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low 7-segment decoder with a blank
// override, shared by every display block.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output seg_t       seg_n
);

    always_comb begin
        seg_n = blank ? SEG_BLANK : GLYPHS[nibble];
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment scan driver: snapshots the CPU GPIO word once per
// frame and walks its nibbles across N_DIGITS common-anode digits.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int N_DIGITS    = 8,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         io2_out,
    input  logic                blank_en,
    input  logic [N_DIGITS-1:0] dp_mask,
    output logic [N_DIGITS-1:0] an_n,
    output logic [6:0]          seg_n,
    output logic                dp_n,
    output logic                frame
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_DIGITS - 1);

    logic [CNT_W-1:0]         cnt;
    logic [IDX_W-1:0]         idx;
    logic [N_DIGITS-1:0][3:0] snap;
    logic [N_DIGITS-1:0][3:0] io_nib;
    logic [N_DIGITS-1:0]      blank_mask;
    logic                     zero_above;
    logic                     tick;
    logic                     wrap;
    seg_t                     cur_seg;

    assign tick = (cnt == CNT_MAX);
    assign wrap = tick && (idx == IDX_MAX);

    // Digits beyond the 32-bit source word read as zero.
    for (genvar i = 0; i < N_DIGITS; i++) begin : g_nib
        if (i < 8) begin : g_src
            assign io_nib[i] = io2_out[4*i +: 4];
        end else begin : g_zero
            assign io_nib[i] = 4'h0;
        end
    end

    // A digit is a leading zero when it and every higher nibble are zero.
    always_comb begin
        zero_above = 1'b1;
        blank_mask = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zero_above    = zero_above & (snap[i] == 4'h0);
            blank_mask[i] = blank_en & zero_above & (i != 0);
        end
    end

    seg7_decode u_decode (
        .nibble (snap[idx]),
        .blank  (blank_mask[idx]),
        .seg_n  (cur_seg)
    );

    always_ff @(posedge clk) begin
        // NOTE: the snapshot is reset along with the control state so the
        // first frame after reset is a defined all-zero value, not garbage.
        if (!rst_n) begin
            cnt   <= '0;
            idx   <= '0;
            snap  <= '0;
            an_n  <= '1;
            seg_n <= SEG_BLANK;
            dp_n  <= 1'b1;
            frame <= 1'b0;
        end else begin
            cnt   <= tick ? '0 : cnt + 1'b1;
            if (tick) begin
                idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
            end
            if (wrap) begin
                snap <= io_nib;
            end
            frame <= wrap;
            an_n  <= ~(N_DIGITS'(1) << idx);
            seg_n <= cur_seg;
            dp_n  <= ~dp_mask[idx];
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed scoreboard bench for seg7_scan_driver with REFRESH_DIV=4, N_DIGITS=8.
module tb_seg7_scan_driver;

    localparam int N   = 8;
    localparam int DIV = 4;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic [31:0] io2_out  = '0;
    logic        blank_en = 1'b1;
    logic [N-1:0] dp_mask = '0;
    logic [N-1:0] an_n;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic        frame;

    typedef struct {
        string        tag;
        logic [N-1:0] an_n;
        logic [6:0]   seg_n;
        logic         dp_n;
    } exp_t;

    exp_t sb[$];

    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    int tests = 0;
    int fails = 0;

    seg7_scan_driver #(
        .N_DIGITS    (N),
        .REFRESH_DIV (DIV)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .io2_out  (io2_out),
        .blank_en (blank_en),
        .dp_mask  (dp_mask),
        .an_n     (an_n),
        .seg_n    (seg_n),
        .dp_n     (dp_n),
        .frame    (frame)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] exp_seg(logic [31:0] val, int d, logic be);
        logic [31:0] upper;
        upper = val >> (4 * d);
        if (be && d != 0 && upper == 32'd0) return 7'h7F;
        return GLYPH[upper[3:0]];
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(string tag);
        check({tag, "_an"},    32'(an_n),  32'hFF);
        check({tag, "_seg"},   32'(seg_n), 32'h7F);
        check({tag, "_dp"},    32'(dp_n),  32'd1);
        check({tag, "_frame"}, 32'(frame), 32'd0);
    endtask

    // Called at the negedge where frame is high (or right after reset release):
    // the next 32 negedges show digits 0..7, ending on the next frame pulse.
    task automatic check_frame(string name, logic [31:0] val, int chg_cycle,
                               logic [31:0] chg_val);
        exp_t e;
        for (int d = 0; d < N; d++) begin
            for (int k = 0; k < DIV; k++) begin
                e.tag   = $sformatf("%s_d%0d_c%0d", name, d, k);
                e.an_n  = ~(8'd1 << d);
                e.seg_n = exp_seg(val, d, blank_en);
                e.dp_n  = ~dp_mask[d];
                sb.push_back(e);
            end
        end
        for (int c = 0; c < N * DIV; c++) begin
            if (c == chg_cycle) io2_out = chg_val;
            @(negedge clk);
            e = sb.pop_front();
            check({e.tag, "_an"},  32'(an_n),  32'(e.an_n));
            check({e.tag, "_seg"}, 32'(seg_n), 32'(e.seg_n));
            check({e.tag, "_dp"},  32'(dp_n),  32'(e.dp_n));
            check({e.tag, "_frame"}, 32'(frame), (c == N * DIV - 1) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        // Reset held three cycles with a zero source word.
        rst_n    = 1'b0;
        io2_out  = 32'h0;
        blank_en = 1'b1;
        dp_mask  = '0;
        repeat (3) @(negedge clk);
        check_reset("in_reset");

        // First frame uses the reset snapshot; 0x12345 waits for the wrap.
        rst_n   = 1'b1;
        io2_out = 32'h0001_2345;
        check_frame("boot", 32'h0, -1, 32'h0);

        // Changing the source mid-display does not alter the shown frame.
        io2_out = 32'h0000_1000;
        check_frame("v12345", 32'h0001_2345, -1, 32'h0);
        check_frame("v1000_blank", 32'h0000_1000, -1, 32'h0);

        blank_en = 1'b0;
        io2_out  = 32'hFFFF_FFFF;
        check_frame("v1000_noblank", 32'h0000_1000, -1, 32'h0);

        // Source drops to zero while digit 3 is on; the F frame must finish.
        check_frame("vF_tear", 32'hFFFF_FFFF, 3 * DIV, 32'h0);

        // Decimal points on digits 0 and 2; digit 2 is also a blanked zero.
        blank_en = 1'b1;
        dp_mask  = 8'h05;
        io2_out  = 32'h0000_9ABC;
        check_frame("dp", 32'h0, -1, 32'h0);

        // Advance to index 5 / tick 2 with snapshot 0x9ABC, then reset mid-scan.
        repeat (5 * DIV + 2) @(posedge clk);
        @(negedge clk);
        check("midscan_an",  32'(an_n),  32'hDF);
        check("midscan_seg", 32'(seg_n), 32'h7F);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset("midscan_rst");
        rst_n = 1'b1;
        check_frame("post_rst", 32'h0, -1, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Downstream consumer of the CPU's 32-bit GPIO output register (io2_out).
- Time-multiplexes the 32-bit value as N_DIGITS hex/BCD nibbles onto a common-anode 7-segment display bank.
- Provides a tear-free frame snapshot, optional leading-zero blanking and per-digit decimal points.
- Sits at top level between the cpu instance and the board display pins.

Parameters:
- N_DIGITS, 8, number of display digits; nibble i of the snapshot drives digit i (digit 0 = least significant nibble).
- REFRESH_DIV, 50000, clock cycles each digit stays enabled (minimum 2).

Ports:
- clk  input  1  system clock, shared with cpu.
- rst_n  input  1  synchronous active-low reset.
- io2_out  input  32  value to display, from the cpu GPIO output register.
- blank_en  input  1  1 = blank leading zero digits.
- dp_mask  input  N_DIGITS  1 = light the decimal point of digit i.
- an_n  output  N_DIGITS  digit enables, active-low, one-hot-low.
- seg_n  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp_n  output  1  decimal point, active-low.
- frame  output  1  one-cycle pulse when the snapshot reloads.

Behaviour:
- Reset is synchronous and active-low, sampled on posedge clk; it overrides all other activity, including mid-scan.
- Reset values:
  - tick counter = 0, digit index = 0, snapshot = 0.
  - an_n = all 1s, seg_n = 7'h7F, dp_n = 1, frame = 0.
- Tick counter:
  - Counts 0 .. REFRESH_DIV-1, then wraps to 0.
  - `tick` is the terminal-count condition (counter == REFRESH_DIV-1).
  - Counter width is $clog2(REFRESH_DIV).
- Digit index:
  - On tick, index advances by 1, modulo N_DIGITS (N_DIGITS-1 -> 0).
  - Index width is $clog2(N_DIGITS), minimum 1.
- Snapshot:
  - Loads io2_out on the cycle where tick is asserted and index == N_DIGITS-1, i.e. coincident with the index wrap.
  - io2_out changes at any other time have no effect on the displayed frame.
  - frame = 1 on the cycle after that load, for exactly one cycle.
- Outputs are registered, 1-cycle latency from index/snapshot state.
  - an_n = ~(1 << index).
  - seg_n = glyph(nibble[index]), or 7'h7F if that digit is blanked.
  - dp_n = ~dp_mask[index].
- Glyphs (active-low):
  - 0: 0x40, 1: 0x79, 2: 0x24, 3: 0x30, 4: 0x19, 5: 0x12, 6: 0x02, 7: 0x78
  - 8: 0x00, 9: 0x10, A: 0x08, b: 0x03, C: 0x46, d: 0x21, E: 0x06, F: 0x0E
- Blanking:
  - Digit i is blanked iff blank_en = 1, i != 0, and snapshot nibbles i .. N_DIGITS-1 are all zero.
  - Zeros between non-zero nibbles are never blanked.
  - Digit 0 always shows its glyph.
  - The decimal point is independent of blanking.
- Nibbles: only io2_out bits [4*N_DIGITS-1:0] are used. If N_DIGITS < 8, upper bits are ignored. If N_DIGITS > 8, nibbles 8 and above read as 0.
- First frame after reset:
  - The snapshot is 0, so digit 0 shows '0' and the other digits follow blank_en.
  - The first real io2_out value appears after the first index wrap, N_DIGITS*REFRESH_DIV cycles after reset release.
- blank_en and dp_mask are sampled live each cycle and are not snapshotted.

Decomposition:
- Package seg7_pkg:
  - SEG_BLANK = 7'h7F.
  - 16-entry glyph constant array.
  - typedef for the 7-bit segment vector.
- Sub-module seg7_decode (combinational):
  - Inputs: nibble, blank. Output: seg_n.
  - Shared with future display blocks.
- The counter, index, snapshot, blank-mask and output registers stay in seg7_scan_driver.

Test Plan (bench uses REFRESH_DIV=4, N_DIGITS=8):
- Reset held 3 cycles, then released, io2_out=0, blank_en=1:
  - During reset: an_n=0xFF, seg_n=0x7F, dp_n=1.
  - Cycles 1-4 after release: an_n=0xFE, seg_n=0x40.
  - Digits 1-7: seg_n=0x7F.
- io2_out=0x00012345, blank_en=1, wait through one index wrap:
  - frame pulses once.
  - Digits 0-4 show 0x12, 0x19, 0x30, 0x24, 0x79.
  - Digits 5-7 show 0x7F.
  - Each digit is held 4 cycles; the an_n sequence is 0xFE, 0xFD, ... 0x7F, then repeats.
- io2_out=0x00001000, blank_en=1:
  - Digits 0-2 show 0x40, digit 3 shows 0x79, digits 4-7 blank.
  - With blank_en=0, all digits except digit 3 show 0x40.
- io2_out changes 0xFFFFFFFF -> 0x00000000 mid-frame (index=3):
  - Remainder of the current frame still shows 0x0E on every digit.
  - New value is visible only after the wrap and the frame pulse.
- dp_mask=0x05, io2_out=0x0:
  - dp_n=0 only while an_n=0xFE or 0xFB.
  - dp_n=0 also on the blanked digit 2 (decimal point is independent of blanking).
- rst_n asserted while index=5 and tick counter=2:
  - Next cycle: all reset values restored.
  - Scan restarts at digit 0 with snapshot 0.
